// File: rtl/bpm_trigger_sequencer.sv
// Sequences the shared fixed-latency BPM divider, sanitises its quotient and runs the beat period counter.
// Optional minimum-period clamp (with sticky o_clamp port) is enabled by defining BPM_SEQ_MIN_PERIOD_EN.
module bpm_trigger_sequencer #(
    parameter int unsigned DIV_LATENCY = 8,
    parameter logic [33:0] MIN_PERIOD  = 34'd1000
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_req_valid,
    input  logic [33:0] i_req_bpm_counter,
    output logic        o_req_ready,
    output logic [39:0] o_div_denom,
    output logic        o_div_aclr,
    input  logic [39:0] i_div_quotient,
    output logic [33:0] o_period,
    output logic        o_period_valid,
    output logic        o_beat,
`ifdef BPM_SEQ_MIN_PERIOD_EN
    output logic        o_clamp,
`endif
    output logic        o_div0_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LOAD = 8'(DIV_LATENCY);

    generate
        if (DIV_LATENCY < 1 || DIV_LATENCY > 255) begin : g_bad_latency
            $error("DIV_LATENCY must lie in 1..255");
        end
        if (MIN_PERIOD == 34'd0) begin : g_bad_min_period
            $error("MIN_PERIOD must be nonzero");
        end
    endgenerate

    // Overflowed or saturated quotients, and zero-denominator requests, give a disabled (0) period
    function automatic logic [33:0] sanitise_quotient(input logic [39:0] quotient,
                                                      input logic [33:0] denom);
        logic [33:0] res;
        if (denom == 34'd0) begin
            res = 34'd0;
        end else if ((&quotient[33:0]) || (|quotient[39:34])) begin
            res = 34'd0;
        end else begin
            res = quotient[33:0];
        end
        return res;
    endfunction

    state_t      state_r;
    state_t      state_next_s;
    logic [7:0]  wait_cnt_r;
    logic [33:0] counter_r;
    logic        div0_err_r;
    logic        ready_s;
    logic        accept_s;
    logic        capture_s;
    logic [33:0] result_raw_s;
    logic [33:0] result_s;
    logic [33:0] pending_r;
    logic        pend_flag_r;
    logic        period_valid_r;
    logic [33:0] period_r;
    logic [33:0] beat_cnt_r;
    logic        beat_r;
    logic        wrap_s;
    logic        apply_s;
`ifdef BPM_SEQ_MIN_PERIOD_EN
    logic        clamp_hit_s;
    logic        clamp_r;
`endif

    // FSM state register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; WAIT leaves when the counter would reach zero so capture lands DIV_LATENCY+1 after accept
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_req_valid) begin
                    if (i_req_bpm_counter == 34'd0) begin
                        state_next_s = ST_CAPTURE;
                    end else begin
                        state_next_s = ST_WAIT;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r <= 8'd1) begin
                    state_next_s = ST_CAPTURE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_CAPTURE: state_next_s = ST_IDLE;
            default:    state_next_s = ST_IDLE;
        endcase
    end

    // FSM output decode
    always_comb begin
        ready_s   = 1'b0;
        capture_s = 1'b0;
        case (state_r)
            ST_IDLE:    ready_s   = 1'b1;
            ST_WAIT:    ready_s   = 1'b0;
            ST_CAPTURE: capture_s = 1'b1;
            default:    ready_s   = 1'b0;
        endcase
        accept_s = ready_s & i_req_valid;
    end

    // Request latch, divider wait counter and sticky zero-denominator flag
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            counter_r  <= 34'd0;
            wait_cnt_r <= 8'd0;
            div0_err_r <= 1'b0;
        end else if (accept_s) begin
            counter_r  <= i_req_bpm_counter;
            wait_cnt_r <= WAIT_LOAD;
            if (i_req_bpm_counter == 34'd0) begin
                div0_err_r <= 1'b1;
            end
        end else if (state_r == ST_WAIT) begin
            wait_cnt_r <= wait_cnt_r - 8'd1;
        end
    end

    // Quotient sanitising and optional minimum-period clamp
    always_comb begin
        result_raw_s = sanitise_quotient(i_div_quotient, counter_r);
`ifdef BPM_SEQ_MIN_PERIOD_EN
        clamp_hit_s = (result_raw_s != 34'd0) && (result_raw_s < MIN_PERIOD);
        if (clamp_hit_s) begin
            result_s = MIN_PERIOD;
        end else begin
            result_s = result_raw_s;
        end
`else
        result_s = result_raw_s;
`endif
    end

    // Beat boundary detection and pending-period apply condition
    always_comb begin
        wrap_s  = 1'b0;
        apply_s = 1'b0;
        if (period_r != 34'd0) begin
            wrap_s = (beat_cnt_r == (period_r - 34'd1));
        end else begin
            wrap_s = 1'b0;
        end
        apply_s = pend_flag_r & ((period_r == 34'd0) | wrap_s);
    end

    // Pending result register; a fresh capture overrides any value not yet applied
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pending_r      <= 34'd0;
            pend_flag_r    <= 1'b0;
            period_valid_r <= 1'b0;
        end else begin
            period_valid_r <= capture_s;
            if (capture_s) begin
                pending_r   <= result_s;
                pend_flag_r <= 1'b1;
            end else if (apply_s) begin
                pend_flag_r <= 1'b0;
            end
        end
    end

`ifdef BPM_SEQ_MIN_PERIOD_EN
    // Sticky clamp indicator
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            clamp_r <= 1'b0;
        end else if (capture_s && clamp_hit_s) begin
            clamp_r <= 1'b1;
        end
    end

    assign o_clamp = clamp_r;
`endif

    // Beat period counter; a new period takes over only on a boundary so no short or double beat occurs
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            period_r   <= 34'd0;
            beat_cnt_r <= 34'd0;
            beat_r     <= 1'b0;
        end else if (period_r == 34'd0) begin
            beat_cnt_r <= 34'd0;
            beat_r     <= 1'b0;
            if (apply_s) begin
                period_r <= pending_r;
            end
        end else if (wrap_s) begin
            beat_cnt_r <= 34'd0;
            beat_r     <= 1'b1;
            if (apply_s) begin
                period_r <= pending_r;
            end
        end else begin
            beat_cnt_r <= beat_cnt_r + 34'd1;
            beat_r     <= 1'b0;
        end
    end

    assign o_req_ready    = ready_s;
    assign o_div_denom    = {6'd0, counter_r};
    assign o_div_aclr     = ~i_reset_n;
    assign o_period       = period_r;
    assign o_period_valid = period_valid_r;
    assign o_beat         = beat_r;
    assign o_div0_err     = div0_err_r;

endmodule

// File: tb/tb_bpm_trigger_sequencer.sv
// Directed self-checking bench for bpm_trigger_sequencer with a pipelined 12e9/denom divider model.
module tb_bpm_trigger_sequencer;

    localparam int          LAT = 8;
    localparam logic [39:0] NUM = 40'd12_000_000_000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic [33:0] req_bpm = 34'd0;
    logic        req_ready;
    logic [39:0] div_denom;
    logic        div_aclr;
    logic [39:0] div_quotient;
    logic [33:0] period;
    logic        period_valid;
    logic        beat;
    logic        div0_err;
`ifdef BPM_SEQ_MIN_PERIOD_EN
    logic        clamp;
`endif

    bpm_trigger_sequencer #(.DIV_LATENCY(LAT), .MIN_PERIOD(34'd1000)) dut (
        .i_clk             (clk),
        .i_reset_n         (rst_n),
        .i_req_valid       (req_valid),
        .i_req_bpm_counter (req_bpm),
        .o_req_ready       (req_ready),
        .o_div_denom       (div_denom),
        .o_div_aclr        (div_aclr),
        .i_div_quotient    (div_quotient),
        .o_period          (period),
        .o_period_valid    (period_valid),
        .o_beat            (beat),
`ifdef BPM_SEQ_MIN_PERIOD_EN
        .o_clamp           (clamp),
`endif
        .o_div0_err        (div0_err)
    );

    always #5 clk = ~clk;

    // Divider model: quotient valid LAT clocks after a stable denominator
    logic [39:0] q_pipe [LAT];
    logic        fq_en = 1'b0;
    logic [39:0] fq_val = 40'd0;
    always @(posedge clk) begin
        q_pipe[0] <= (div_denom == 40'd0) ? {40{1'b1}} : NUM / div_denom;
        for (int i = 1; i < LAT; i++) q_pipe[i] <= q_pipe[i-1];
    end
    assign div_quotient = fq_en ? fq_val : q_pipe[LAT-1];

    int cyc = 0;
    int beat_q[$];
    int hs_q[$];
    int pv_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (beat) beat_q.push_back(cyc);
        if (req_valid && req_ready) hs_q.push_back(cyc);
        if (period_valid) pv_cnt <= pv_cnt + 1;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [33:0] v);
        req_bpm   = v;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_pv(output int n);
        n = 0;
        while (n <= 400) begin
            tick();
            n++;
            if (period_valid) break;
        end
    endtask

    task automatic wait_beat(output int n);
        n = 0;
        while (n <= 1000) begin
            tick();
            n++;
            if (beat) break;
        end
    endtask

    function automatic int gap(input int base, input int k);
        if (base + k < beat_q.size()) return beat_q[base+k] - beat_q[base+k-1];
        return -1;
    endfunction

    initial begin
        int n;
        int b0;
        int bq0;
        int hq0;
        int pv0;
        logic [39:0] bad_q [2];
        bad_q[0] = 40'h03_FFFF_FFFF;
        bad_q[1] = 40'h04_0000_00F0;

        #2 rst_n = 1'b0;
        repeat (3) tick();
        check_val("rst_aclr", div_aclr, 1);
        check_val("rst_ready", req_ready, 1);
        check_val("rst_period", period, 0);
        check_val("rst_beat", beat, 0);
        check_val("rst_err", div0_err, 0);
        check_val("rst_pv", period_valid, 0);
        rst_n = 1'b1;
        tick();
        check_val("run_aclr", div_aclr, 0);
        check_val("idle_ready", req_ready, 1);

        bq0 = beat_q.size();
        repeat (1000) tick();
        check_val("idle_beats", beat_q.size() - bq0, 0);
        check_val("idle_period", period, 0);

        // First request from disabled state: 12e9 / 50e6 = 240
        send(34'd50_000_000);
        check_val("wait_ready", req_ready, 0);
        check_val("wait_denom", div_denom, 40'd50_000_000);
        wait_pv(n);
        check_val("lat_240", n, 9);
        check_val("pre_apply_period", period, 0);
        tick();
        check_val("period_240", period, 240);
        check_val("pv_pulse_width", period_valid, 0);
        wait_beat(n);
        check_val("first_beat_240", n, 240);
        wait_beat(n);
        check_val("beat_gap_240", n, 240);

        // Shorter period applies only at the next boundary
        b0  = cyc;
        bq0 = beat_q.size();
        send(34'd100_000_000);
        wait_pv(n);
        check_val("lat_120", n, 9);
        while (cyc < b0 + 500) tick();
        check_val("chg_beats", beat_q.size() - bq0, 4);
        check_val("chg_gap0", gap(bq0, 1), 240);
        check_val("chg_gap1", gap(bq0, 2), 120);
        check_val("chg_gap2", gap(bq0, 3), 120);
        check_val("period_120", period, 120);

        // Held request during WAIT and two captures inside one beat: last wins (200e6 -> 60)
        wait_beat(n);
        check_val("sync_beat", n <= 120, 1);
        b0  = cyc;
        bq0 = beat_q.size();
        hq0 = hs_q.size();
        req_bpm   = 34'd50_000_000;
        req_valid = 1'b1;
        tick();
        req_bpm = 34'd200_000_000;
        tick();
        check_val("busy_ready", req_ready, 0);
        wait_pv(n);
        check_val("lat_a", n, 8);
        tick();
        req_valid = 1'b0;
        wait_pv(n);
        check_val("lat_b", n, 9);
        check_val("hs_count", hs_q.size() - hq0, 2);
        if (hs_q.size() - hq0 == 2) check_val("hs_gap", hs_q[hq0+1] - hs_q[hq0], 10);
        while (cyc < b0 + 310) tick();
        check_val("b2b_beats", beat_q.size() - bq0, 5);
        check_val("b2b_gap0", gap(bq0, 1), 120);
        check_val("b2b_gap1", gap(bq0, 2), 60);
        check_val("b2b_gap2", gap(bq0, 3), 60);
        check_val("b2b_gap3", gap(bq0, 4), 60);
        check_val("period_60", period, 60);

        // Zero request: immediate capture, sticky error, beats stop at boundary
        wait_beat(n);
        b0  = cyc;
        bq0 = beat_q.size();
        send(34'd0);
        wait_pv(n);
        check_val("lat_zero", n, 1);
        check_val("div0_err_set", div0_err, 1);
        check_val("zero_pending_period", period, 60);
        while (cyc < b0 + 200) tick();
        check_val("zero_beats", beat_q.size() - bq0, 2);
        check_val("zero_period", period, 0);
        check_val("div0_err_sticky", div0_err, 1);

        // Reset in the middle of WAIT discards the request
        send(34'd50_000_000);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_val("abort_ready", req_ready, 1);
        check_val("abort_aclr", div_aclr, 1);
        check_val("abort_err", div0_err, 0);
        tick();
        rst_n = 1'b1;
        pv0 = pv_cnt;
        repeat (30) tick();
        check_val("abort_no_pv", pv_cnt - pv0, 0);
        check_val("abort_period", period, 0);

        // Saturated and overflowed quotients give a disabled period
        for (int k = 0; k < 2; k++) begin
            send(34'd100_000_000);
            wait_pv(n);
            tick();
            check_val("san_setup", period, 120);
            fq_en  = 1'b1;
            fq_val = bad_q[k];
            send(34'd5);
            wait_pv(n);
            check_val("san_lat", n, 9);
            fq_en = 1'b0;
            wait_beat(n);
            check_val("san_period", period, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bpm_trigger_sequencer.md
Name: bpm_trigger_sequencer

Overview:
- Controller that sequences the shared pipelined BPM divider (fixed numerator, 40-bit, fixed latency, no start/valid strobes).
- Accepts measured BPM counter values over a valid/ready handshake and drives the divider denominator stable for the full pipeline latency.
- Captures and sanitises the quotient, then runs the beat period counter that emits one-cycle beat pulses.
- Sits between the tap/BPM measurement logic and the metronome sound/LED outputs.

Parameters:
- DIV_LATENCY, 8, divider pipeline depth in clocks from a stable denominator to a valid quotient (1..255).
- MIN_PERIOD, 34'd1000, smallest permitted beat period in clocks; used only with the optional feature.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous active-low reset
- i_req_valid  in  1  new BPM counter value offered
- i_req_bpm_counter  in  34  measured clocks per tap
- o_req_ready  out  1  sequencer can accept a request
- o_div_denom  out  40  divider denominator, {6'b0, latched counter}
- o_div_aclr  out  1  divider clear; asserted while i_reset_n is low
- i_div_quotient  in  40  divider quotient
- o_period  out  34  active beat period in clocks (0 = beats disabled)
- o_period_valid  out  1  one-cycle pulse when a new result is captured
- o_beat  out  1  one-cycle beat pulse
- o_div0_err  out  1  sticky; set on a zero-denominator request

Behaviour:
- Reset (async assert, sync release): all registered outputs are 0, state IDLE, beat counter 0, pending flag 0, o_div_aclr = ~i_reset_n.
- States:
  - IDLE: o_req_ready = 1. On i_req_valid, latch the counter.
    - Counter == 0: go to CAPTURE with result 0 and set o_div0_err.
    - Otherwise: go to WAIT and load the wait counter with DIV_LATENCY.
  - WAIT: o_req_ready = 0, o_div_denom held constant. Decrement each clock; at 0 go to CAPTURE. Total from accept to CAPTURE = DIV_LATENCY+1 clocks.
  - CAPTURE: result = 0 if quotient[33:0] == all ones or quotient[39:34] != 0, else quotient[33:0]. Write result to the pending register, set the pending flag, pulse o_period_valid, return to IDLE.
- Requests arriving while busy are not accepted (held off by o_req_ready = 0). There is no queue; the requester holds valid.
- Beat counter:
  - When o_period != 0, count 0..o_period-1. On reaching o_period-1, pulse o_beat and wrap to 0.
  - When o_period == 0, the counter is held at 0 and o_beat stays 0.
- Period update:
  - Pending applies at the next beat boundary (same cycle as o_beat). The count restarts at 0 with the new period and the pending flag clears.
  - If the active period is 0, pending applies on the clock after CAPTURE and the first beat follows a full new period.
  - A pending value of 0 disables beats at the boundary.
  - A new CAPTURE before an old pending value applies overwrites it; last value wins.
- o_div0_err clears only on reset.
- Mid-operation reset aborts WAIT immediately. The result is discarded and no o_period_valid pulse is produced.

Optional Feature:
- Macro: BPM_SEQ_MIN_PERIOD_EN.
- Defined: in CAPTURE, a nonzero result below MIN_PERIOD is replaced with MIN_PERIOD, and a sticky o_clamp flag port (out, 1, reset 0) is set.
- Undefined: no clamp, no o_clamp port, results pass as computed.

Test Plan:
- Reset then idle: o_period=0, o_beat never asserts over 1000 clocks, o_req_ready=1.
- Request 50_000_000 with a divider model returning 12e9/denom after DIV_LATENCY=8: o_period_valid exactly 9 clocks after the handshake, o_period=240, o_beat every 240 clocks, first beat 240 clocks after apply.
- Request 0: no wait, o_period_valid the next clock, o_period=0, o_div0_err=1, beats stop.
- Running at period 240, then request giving 120: the old period completes and the first o_beat after apply is 120 clocks later, no short or double beat.
- Second i_req_valid during WAIT: not accepted until IDLE. Two back-to-back captures inside one beat: only the last period applies.
- With BPM_SEQ_MIN_PERIOD_EN and MIN_PERIOD=1000, request yielding quotient 240: o_period=1000, o_clamp=1.
